sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_wait_cnt.sv | 35 +++
 rtl/sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared FSM state type and constants for the AVR/SRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } sram_state_t;

    // Bus-buffer direction encoding
    localparam logic DIR_AVR2SRAM = 1'b0;
    localparam logic DIR_SRAM2AVR = 1'b1;

    localparam int c_WAIT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/sram_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : sram_wait_cnt
// Purpose  : Loadable down-counter with zero flag that times the strobe phase.
// Revision : 1.0 - initial release
// ============================================================================
module sram_wait_cnt
    import sram_pkg::*;
#(
    parameter int WIDTH = c_WAIT_CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Sequences AVR read/write requests into timed SRAM strobe cycles.
// Options  : SRAM_AUTOINC_EN - address register loaded by avr_addr_load and
//            post-incremented after every access.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int AWIDTH      = 19,
    parameter int WAIT_CYCLES = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              avr_req,
    input  logic              avr_rw,
    input  logic [AWIDTH-1:0] avr_addr,
    input  logic              avr_addr_load,
    output logic              avr_ack,
    output logic              busy,
    output logic [AWIDTH-1:0] sram_addr,
    output logic              sram_dir,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD = c_WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_t       r_state;
    sram_state_t       w_state_nxt;
    logic              r_rw;
    logic              w_rw_nxt;
    logic [AWIDTH-1:0] r_addr;
    logic              w_accept;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;

    logic              r_ce_n, r_oe_n, r_we_n, r_dir, r_ack;
    logic              w_ce_n_nxt, w_oe_n_nxt, w_we_n_nxt, w_dir_nxt, w_ack_nxt;

    assign w_accept = (r_state == ST_IDLE) && avr_req;

    sram_wait_cnt #(
        .WIDTH      (c_WAIT_CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (c_WAIT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rw    <= DIR_SRAM2AVR;
        end else begin
            r_state <= w_state_nxt;
            r_rw    <= w_rw_nxt;
        end
    end

    // Strobes are decoded from the next state so the registered outputs line up with r_state
    always_comb begin
        w_state_nxt = r_state;
        w_rw_nxt    = r_rw;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_dir_nxt   = DIR_SRAM2AVR;
        w_ack_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_rw_nxt    = avr_rw;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
                w_cnt_load  = 1'b1;
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_HOLD:  w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_SETUP, ST_HOLD: begin
                w_ce_n_nxt = 1'b0;
                w_dir_nxt  = w_rw_nxt ? DIR_SRAM2AVR : DIR_AVR2SRAM;
            end
            ST_ACCESS: begin
                w_ce_n_nxt = 1'b0;
                w_dir_nxt  = w_rw_nxt ? DIR_SRAM2AVR : DIR_AVR2SRAM;
                w_oe_n_nxt = ~w_rw_nxt;
                w_we_n_nxt = w_rw_nxt;
            end
            ST_DONE: begin
                w_ack_nxt = 1'b1;
            end
            default: begin
                w_ce_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_we_n <= 1'b1;
            r_dir  <= DIR_SRAM2AVR;
            r_ack  <= 1'b0;
        end else begin
            r_ce_n <= w_ce_n_nxt;
            r_oe_n <= w_oe_n_nxt;
            r_we_n <= w_we_n_nxt;
            r_dir  <= w_dir_nxt;
            r_ack  <= w_ack_nxt;
        end
    end

`ifdef SRAM_AUTOINC_EN
    // A load in the same IDLE cycle as a request supplies that access's address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if ((r_state == ST_IDLE) && avr_addr_load) begin
            r_addr <= avr_addr;
        end else if (r_state == ST_DONE) begin
            r_addr <= r_addr + AWIDTH'(1);
        end
    end
`else
    logic w_unused_addr_load;
    assign w_unused_addr_load = avr_addr_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= avr_addr;
        end
    end
`endif

    assign avr_ack   = r_ack;
    assign busy      = (r_state != ST_IDLE);
    assign sram_addr = r_addr;
    assign sram_dir  = r_dir;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Directed self-checking bench for sram_ctrl (WAIT_CYCLES 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          a_req, a_rw, a_load;
    logic [AW-1:0] a_addr;
    logic          a_ack, a_busy, a_dir, a_ce_n, a_oe_n, a_we_n;
    logic [AW-1:0] a_saddr;
    logic [5:0]    a_st;

    logic          b_req, b_rw, b_load;
    logic [AW-1:0] b_addr;
    logic          b_ack, b_busy, b_dir, b_ce_n, b_oe_n, b_we_n;
    logic [AW-1:0] b_saddr;

    int n_vec = 0;
    int n_err = 0;

    sram_ctrl #(.AWIDTH(AW), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .avr_req(a_req), .avr_rw(a_rw),
        .avr_addr(a_addr), .avr_addr_load(a_load), .avr_ack(a_ack),
        .busy(a_busy), .sram_addr(a_saddr), .sram_dir(a_dir),
        .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n)
    );

    sram_ctrl #(.AWIDTH(AW), .WAIT_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .avr_req(b_req), .avr_rw(b_rw),
        .avr_addr(b_addr), .avr_addr_load(b_load), .avr_ack(b_ack),
        .busy(b_busy), .sram_addr(b_saddr), .sram_dir(b_dir),
        .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n)
    );

    // {ce_n, oe_n, we_n, dir, ack, busy}
    assign a_st = {a_ce_n, a_oe_n, a_we_n, a_dir, a_ack, a_busy};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WAIT_CYCLES=2 access on DUT A, checked cycle by cycle after the sampling edge
    task automatic run_access(input string tag, input logic rw, input logic [AW-1:0] addr,
                              input logic load, input logic [AW-1:0] exp_addr);
        logic [5:0] exp_st [1:6];
        if (rw)
            exp_st = '{6'b011101, 6'b001101, 6'b001101, 6'b011101, 6'b111111, 6'b111100};
        else
            exp_st = '{6'b011001, 6'b010001, 6'b010001, 6'b011001, 6'b111111, 6'b111100};
        @(negedge clk);
        a_req  = 1'b1;
        a_rw   = rw;
        a_addr = addr;
        a_load = load;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_req  = 1'b0;
                a_load = 1'b0;
                a_addr = '0;
            end
            check($sformatf("%s_st_k%0d", tag, k), 32'(a_st), 32'(exp_st[k]));
            if (k <= 4)
                check($sformatf("%s_addr_k%0d", tag, k), 32'(a_saddr), 32'(exp_addr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_ack;
        rst_n  = 1'b0;
        a_req  = 1'b0; a_rw = 1'b1; a_addr = '0; a_load = 1'b0;
        b_req  = 1'b0; b_rw = 1'b1; b_addr = 19'h00042; b_load = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_st",    32'(a_st),    32'(6'b111100));
        check("rst_addr",  32'(a_saddr), 32'h0);
        check("rst_b_ack", 32'(b_ack),   32'h0);
        check("rst_b_bsy", 32'(b_busy),  32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(a_st), 32'(6'b111100));

        run_access("rd123",   1'b1, 19'h00123, 1'b1, 19'h00123);
        run_access("wr7ffff", 1'b0, 19'h7FFFF, 1'b1, 19'h7FFFF);

        // Reset asserted while a write is in its strobe phase
        @(negedge clk);
        a_req = 1'b1; a_rw = 1'b0; a_addr = 19'h55555; a_load = 1'b1;
        @(negedge clk);
        a_req = 1'b0; a_load = 1'b0;
        @(negedge clk);
        check("mid_wr_st",   32'(a_st),    32'(6'b010001));
        check("mid_wr_addr", 32'(a_saddr), 32'h55555);
        rst_n = 1'b0;
        #1;
        check("rst_mid_st",   32'(a_st),    32'(6'b111100));
        check("rst_mid_addr", 32'(a_saddr), 32'h0);
        repeat (2) @(negedge clk);
        check("rst_hold_st", 32'(a_st), 32'(6'b111100));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_st", 32'(a_st), 32'(6'b111100));

`ifdef SRAM_AUTOINC_EN
        run_access("inc0", 1'b1, 19'h7FFFE, 1'b1, 19'h7FFFE);
        run_access("inc1", 1'b1, 19'h01234, 1'b0, 19'h7FFFF);
        run_access("inc2", 1'b1, 19'h01234, 1'b0, 19'h00000);
`else
        run_access("lat0", 1'b1, 19'h7FFFE, 1'b0, 19'h7FFFE);
        run_access("lat1", 1'b1, 19'h01234, 1'b0, 19'h01234);
        run_access("lat2", 1'b1, 19'h00ABC, 1'b1, 19'h00ABC);
`endif

        // WAIT_CYCLES=1 with request held high: one access every 5 cycles
        n_ack = 0;
        @(negedge clk);
        b_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) b_req = 1'b0;
            if (b_ack) n_ack++;
            check($sformatf("cont_ack_k%0d", k), 32'(b_ack),  32'((k % 5) == 4));
            check($sformatf("cont_bsy_k%0d", k), 32'(b_busy), 32'((k % 5) != 0));
        end
        check("cont_ack_total", 32'(n_ack), 32'd4);

        // Request pulses while busy must not produce another access
        @(negedge clk);
        b_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) b_req = 1'b0;
            if (k == 2) b_req = 1'b1;
            if (k == 3) b_req = 1'b0;
            check($sformatf("pulse_ack_k%0d", k), 32'(b_ack),  32'(k == 4));
            check($sformatf("pulse_bsy_k%0d", k), 32'(b_busy), 32'(k <= 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
